// File: rtl/tt_pin_cmd_responder.sv
// Slave end of the host byte-strobe protocol: header/data decode
// against a small register bank with a read-only status window on top.
module tt_pin_cmd_responder #(
  parameter int NREGS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       stb,
  output logic       ack,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       err,
  input  logic [7:0] status_in,
  output logic [7:0] cfg0,
  output logic [7:0] cfg1
);

  localparam int AW = $clog2(NREGS);
  localparam logic [3:0] AMASK = 4'(NREGS - 1);
  localparam logic [AW-1:0] TOP = AW'(NREGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_REL,
    S_WDATA_REL,
    S_WDATA,
    S_DATA_REL
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stb_d;
  state_t                 r_state;
  state_t                 w_nxt;
  logic [AW-1:0]          r_addr;
  logic [7:0]             r_regs [NREGS];
  logic                   r_ack;
  logic [7:0]             r_dout;
  logic                   r_dout_vld;
  logic                   r_err;

  logic          w_stb_s;
  logic          w_rise;
  logic          w_fall;
  logic          w_hdr_ok;
  logic [AW-1:0] w_hdr_addr;
  logic [7:0]    w_rdata;
  logic          w_accept;
  logic          w_ld_rd;
  logic          w_clr_vld;
  logic          w_set_err;
  logic          w_wr;
  logic          w_ld_addr;

  assign w_stb_s    = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_stb_s & ~r_stb_d;
  assign w_fall     = ~w_stb_s & r_stb_d;
  assign w_hdr_ok   = (din[6:4] == 3'd0)
                    && ((din[3:0] & ~AMASK) == 4'd0);
  assign w_hdr_addr = din[AW-1:0];
  // Top address is the live status input, never the stored entry.
  assign w_rdata    = (w_hdr_addr == TOP) ? status_in
                                          : r_regs[w_hdr_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_stb_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], stb};
      r_stb_d <= w_stb_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_accept  = 1'b0;
    w_ld_rd   = 1'b0;
    w_clr_vld = 1'b0;
    w_set_err = 1'b0;
    w_wr      = 1'b0;
    w_ld_addr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_accept  = 1'b1;
          w_clr_vld = 1'b1;
          if (!w_hdr_ok) begin
            w_set_err = 1'b1;
            w_nxt     = S_HDR_REL;
          end else if (din[7]) begin
            w_ld_rd = 1'b1;
            w_nxt   = S_HDR_REL;
          end else begin
            w_ld_addr = 1'b1;
            w_nxt     = S_WDATA_REL;
          end
        end
      end
      S_HDR_REL: begin
        if (w_fall) w_nxt = S_IDLE;
      end
      S_WDATA_REL: begin
        if (w_fall) w_nxt = S_WDATA;
      end
      S_WDATA: begin
        if (w_rise) begin
          w_accept = 1'b1;
          if (r_addr == TOP) w_set_err = 1'b1;
          else               w_wr      = 1'b1;
          w_nxt = S_DATA_REL;
        end
      end
      S_DATA_REL: begin
        if (w_fall) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept)    r_ack <= 1'b1;
      else if (w_fall) r_ack <= 1'b0;
      if (w_ld_addr) r_addr <= w_hdr_addr;
      if (w_ld_rd) begin
        r_dout     <= w_rdata;
        r_dout_vld <= 1'b1;
      end else if (w_clr_vld) begin
        r_dout_vld <= 1'b0;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[r_addr] <= din;
    end
  end

  assign ack      = r_ack;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign err      = r_err;
  assign cfg0     = r_regs[0];
  assign cfg1     = r_regs[1];

endmodule

// File: tb/tb_tt_pin_cmd_responder.sv
// Scoreboard bench for tt_pin_cmd_responder: expected state is queued
// per byte and checked by a monitor on each ack rising edge.
module tb_tt_pin_cmd_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] status_in = 8'h00;
  logic       ack;
  logic [7:0] dout;
  logic       dout_vld;
  logic       err;
  logic [7:0] cfg0;
  logic [7:0] cfg1;

  tt_pin_cmd_responder #(
    .NREGS(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .stb(stb),
    .ack(ack),
    .dout(dout),
    .dout_vld(dout_vld),
    .err(err),
    .status_in(status_in),
    .cfg0(cfg0),
    .cfg1(cfg1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dout;
    logic       dv;
    logic       err;
    logic [7:0] c0;
    logic [7:0] c1;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", name, act, req);
    end
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack === 1'b1 && prev !== 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack with empty queue");
        end else begin
          e = q.pop_front();
          chk("dout", dout, e.dout);
          chk("dout_vld", {7'd0, dout_vld}, {7'd0, e.dv});
          chk("err", {7'd0, err}, {7'd0, e.err});
          chk("cfg0", cfg0, e.c0);
          chk("cfg1", cfg1, e.c1);
        end
      end
      prev = ack;
    end
  end

  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (ack !== lvl && n < 20);
    chk("ack_wait", {7'd0, ack}, {7'd0, lvl});
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e_dout,
                      input logic e_dv, input logic e_err,
                      input logic [7:0] e_c0, input logic [7:0] e_c1,
                      input bit timing);
    int n;
    q.push_back(exp_t'{e_dout, e_dv, e_err, e_c0, e_c1});
    @(negedge clk);
    din = b;
    stb = 1'b1;
    wait_ack(1'b1, n);
    if (timing) chk("rise_latency", 8'(n), 8'd3);
    @(negedge clk);
    stb = 1'b0;
    wait_ack(1'b0, n);
    if (timing) chk("fall_latency", 8'(n), 8'd3);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    stb = 1'b1;
    din = 8'h81;
    repeat (2) @(negedge clk);
    chk("rst_ack", {7'd0, ack}, 8'd0);
    chk("rst_dout_vld", {7'd0, dout_vld}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_cfg0", cfg0, 8'h00);
    chk("rst_cfg1", cfg1, 8'h00);
    q.push_back(exp_t'{8'h00, 1'b1, 1'b0, 8'h00, 8'h00});
    rst = 1'b0;
    wait_ack(1'b1, n);
    chk("rst_release_latency", 8'(n), 8'd3);
    @(negedge clk);
    stb = 1'b0;
    wait_ack(1'b0, n);
    repeat (2) @(negedge clk);

    send(8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    send(8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);
    send(8'h81, 8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0);
    send(8'h80, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1);
    send(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);
    send(8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0);

    status_in = 8'h3C;
    send(8'h8F, 8'h3C, 1'b1, 1'b0, 8'h5A, 8'hA5, 1'b0);
    send(8'h0F, 8'h3C, 1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0);
    send(8'h55, 8'h3C, 1'b0, 1'b1, 8'h5A, 8'hA5, 1'b0);

    send(8'h01, 8'h3C, 1'b0, 1'b1, 8'h5A, 8'hA5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_err", {7'd0, err}, 8'd0);
    chk("midrst_dout_vld", {7'd0, dout_vld}, 8'd0);
    chk("midrst_cfg0", cfg0, 8'h00);
    chk("midrst_cfg1", cfg1, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h81, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    send(8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    send(8'h77, 8'h00, 1'b0, 1'b0, 8'h00, 8'h77, 1'b0);
    send(8'h90, 8'h00, 1'b0, 1'b1, 8'h00, 8'h77, 1'b0);
    send(8'h80, 8'h00, 1'b1, 1'b1, 8'h00, 8'h77, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
